// File: rtl/irq_pending_ctrl_if.sv
// Bundle of request, mask, dispatch handshake and pending status signals for irq_pending_ctrl.
// The overflow status signal exists only when IRQ_OVERFLOW_EN is defined.
interface irq_pending_ctrl_if;
  logic [3:0] irq_in;
  logic [3:0] mask;
  logic       irq_valid;
  logic [1:0] irq_id;
  logic       irq_ack;
  logic [3:0] pending;
`ifdef IRQ_OVERFLOW_EN
  logic [3:0] overflow;
`endif

`ifdef IRQ_OVERFLOW_EN
  modport master (output irq_in, mask, irq_ack,
                  input  irq_valid, irq_id, pending, overflow);
  modport slave  (input  irq_in, mask, irq_ack,
                  output irq_valid, irq_id, pending, overflow);
`else
  modport master (output irq_in, mask, irq_ack,
                  input  irq_valid, irq_id, pending);
  modport slave  (input  irq_in, mask, irq_ack,
                  output irq_valid, irq_id, pending);
`endif
endinterface

// File: rtl/irq_pending_ctrl.sv
// Interrupt capture and dispatch: synchronise, detect rising edges, hold sticky pending bits, and
// present the highest unmasked line with valid/ack. Optional IRQ_OVERFLOW_EN adds merged-event flags.
module irq_pending_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  irq_pending_ctrl_if.slave bus
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t     state_reg;
  logic [3:0] sync_out;
  logic [3:0] prev_reg;
  logic [3:0] rise;
  logic [3:0] pending_reg;
  logic [3:0] elig;
  logic [3:0] clr;
  logic       irq_valid_reg;
  logic [1:0] irq_id_reg;
  logic [1:0] sel_id;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain_reg <= '0;
        else        chain_reg <= {chain_reg[SYNC_STAGES-2:0], bus.irq_in[gi]};
      end
      assign sync_out[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_reg <= '0;
    else        prev_reg <= sync_out;
  end

  assign rise = sync_out & ~prev_reg;
  assign elig = pending_reg & ~bus.mask;
  assign clr  = (state_reg == PRESENT && bus.irq_ack) ? (4'b0001 << irq_id_reg) : 4'b0000;

  always_comb begin
    sel_id = 2'd0;
    if      (elig[3]) sel_id = 2'd3;
    else if (elig[2]) sel_id = 2'd2;
    else if (elig[1]) sel_id = 2'd1;
  end

  // A fresh edge in the ack cycle wins over the clear, so the line is re-dispatched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_reg <= '0;
    else        pending_reg <= (pending_reg & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      irq_valid_reg <= 1'b0;
      irq_id_reg    <= 2'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (elig != 4'b0000) begin
            state_reg     <= PRESENT;
            irq_valid_reg <= 1'b1;
            irq_id_reg    <= sel_id;
          end
        end
        PRESENT: begin
          // ID stays frozen until the consumer takes it.
          if (bus.irq_ack) begin
            state_reg     <= IDLE;
            irq_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          irq_valid_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef IRQ_OVERFLOW_EN
  logic [3:0] overflow_reg;
  logic [3:0] ovf_set;

  assign ovf_set = rise & pending_reg & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_reg <= '0;
    else        overflow_reg <= (overflow_reg & ~clr) | ovf_set;
  end

  assign bus.overflow = overflow_reg;
`endif

  assign bus.pending   = pending_reg;
  assign bus.irq_valid = irq_valid_reg;
  assign bus.irq_id    = irq_id_reg;

endmodule
